reg_wb_arbiter: RTL

Writeback arbiter that drives the register file's single write port (WEN/WA3/WD3) from two producers: the single-cycle ALU path and a multi-cycle path (loads, divider). ALU results have fixed priority and never stall. Multi-cycle results enter through a valid/ready handshake and are buffered in a small FIFO until the port is free. A pending-destination scoreboard lets decode detect reads of registers whose writeback has not yet happened.

---
 rtl/reg_wb_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter
//
// Writeback arbiter for the register file's single write port. ALU results
// have fixed priority and never stall. Multi-cycle results (loads, divider)
// arrive on a valid/ready handshake and wait in a small circular FIFO until
// the port is free. A pending-destination scoreboard lets decode detect reads
// of registers whose writeback has not happened yet.
//
// Optional feature: define WB_BYPASS_EN to let an mc result go straight to the
// write port when the ALU is idle and the FIFO is empty (1-edge mc latency).
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   alu_valid/alu_addr/alu_data      single-cycle ALU result
//   mc_valid/mc_ready/mc_addr/mc_data multi-cycle result handshake
//   issue_valid/issue_addr           mark a destination as pending
//   q1_addr/q2_addr -> q1_pend/q2_pend  combinational pending query
//   WEN/WA3/WD3                      registered register-file write port

module reg_wb_arbiter #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [ADDRESS_WIDTH-1:0] alu_addr,
    input  logic [WORD_WIDTH-1:0]    alu_data,
    input  logic                     mc_valid,
    output logic                     mc_ready,
    input  logic [ADDRESS_WIDTH-1:0] mc_addr,
    input  logic [WORD_WIDTH-1:0]    mc_data,
    input  logic                     issue_valid,
    input  logic [ADDRESS_WIDTH-1:0] issue_addr,
    input  logic [ADDRESS_WIDTH-1:0] q1_addr,
    input  logic [ADDRESS_WIDTH-1:0] q2_addr,
    output logic                     q1_pend,
    output logic                     q2_pend,
    output logic                     WEN,
    output logic [ADDRESS_WIDTH-1:0] WA3,
    output logic [WORD_WIDTH-1:0]    WD3
);

    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned NumRegs = 1 << ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]    fifo_data_q [FIFO_DEPTH];

    logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]          count_q, count_d;
    logic [NumRegs-1:0]       pend_q, pend_d;
    logic                     wen_q, wen_d;
    logic [ADDRESS_WIDTH-1:0] wa3_q, wa3_d;
    logic [WORD_WIDTH-1:0]    wd3_q, wd3_d;

    logic mc_fire;
    logic mc_bypass;
    logic push;
    logic pop;
    logic fifo_empty;

    // Ready comes from the registered count only, so a same-cycle pop never
    // reopens a full FIFO.
    assign mc_ready   = (count_q < CntW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign mc_fire    = mc_valid & mc_ready;

`ifdef WB_BYPASS_EN
    assign mc_bypass = mc_fire & (mc_addr != '0) & ~alu_valid & fifo_empty;
`else
    assign mc_bypass = 1'b0;
`endif

    // Address-0 transfers complete the handshake but are dropped here.
    assign push = mc_fire & (mc_addr != '0) & ~mc_bypass;
    assign pop  = ~alu_valid & ~fifo_empty;

    always_comb begin
        wen_d = 1'b0;
        wa3_d = wa3_q;
        wd3_d = wd3_q;
        if (alu_valid) begin
            // ALU owns the port even for address 0; that case just writes nothing.
            if (alu_addr != '0) begin
                wen_d = 1'b1;
                wa3_d = alu_addr;
                wd3_d = alu_data;
            end
        end else if (pop) begin
            wen_d = 1'b1;
            wa3_d = fifo_addr_q[rd_ptr_q];
            wd3_d = fifo_data_q[rd_ptr_q];
        end else if (mc_bypass) begin
            wen_d = 1'b1;
            wa3_d = mc_addr;
            wd3_d = mc_data;
        end
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    // Clear on the edge that writes, then set, so a same-edge issue wins.
    always_comb begin
        pend_d = pend_q;
        if (wen_d) begin
            pend_d[wa3_d] = 1'b0;
        end
        if (issue_valid) begin
            pend_d[issue_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= '0;
            wen_q    <= 1'b0;
            wa3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            wen_q    <= wen_d;
            wa3_q    <= wa3_d;
            wd3_q    <= wd3_d;
        end
    end

    // Storage needs no reset: count and pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= mc_addr;
            fifo_data_q[wr_ptr_q] <= mc_data;
        end
    end

    assign q1_pend = pend_q[q1_addr];
    assign q2_pend = pend_q[q2_addr];
    assign WEN     = wen_q;
    assign WA3     = wa3_q;
    assign WD3     = wd3_q;

endmodule
